axi_line_reader: RTL

AXI_LINE_READER -- requirements
Module: axi_line_reader

---
 rtl/axi_pkg.sv | 38 +++
 rtl/axi_line_reader_if.sv | 12 +
 rtl/axi_lr_ar_gen.sv | 79 +++++++
 rtl/axi_line_reader.sv | 130 +++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI read-channel types, protocol constants and reader FSM states.
`define HI 1'b1
`define LO 1'b0

package axi_pkg;

  localparam int unsigned AxiIdW   = 4;
  localparam int unsigned AxiAddrW = 64;
  localparam int unsigned AxiDataW = 128;

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [3:0] ArCache   = 4'b0011;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiAddrW-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic                valid;
  } axi_ar_t;

  typedef struct packed {
    logic [AxiIdW-1:0]   id;
    logic [AxiDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
    logic                valid;
  } axi_r_t;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} lr_state_e;

endpackage

// File: rtl/axi_line_reader_if.sv
// AR/R channel bundle between the line reader (master) and the interconnect (slave).
interface axi_line_reader_if;
  import axi_pkg::*;

  axi_ar_t axi_ar;
  logic    axi_arready;
  axi_r_t  axi_r;
  logic    axi_rready;

  modport master (output axi_ar, output axi_rready, input axi_arready, input axi_r);
  modport slave  (input axi_ar, input axi_rready, output axi_arready, output axi_r);
endinterface

// File: rtl/axi_lr_ar_gen.sv
// AR issue side: burst address, issued/completed burst counters, outstanding limit.
module axi_lr_ar_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W          = 29,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned BURST_LEN       = 240,
  parameter int unsigned BURSTS_PER_REQ  = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              issue_i,
  input  logic              arready_i,
  input  logic              burst_done_i,
  output axi_ar_t           ar_o,
  output logic [7:0]        ar_cnt_o,
  output logic [7:0]        r_burst_cnt_o
);

  localparam logic [ADDR_W-1:0] AddrInc   = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [7:0]        NumBursts = 8'(BURSTS_PER_REQ);
  localparam logic [7:0]        MaxOut    = 8'(MAX_OUTSTANDING);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        ar_cnt_q, ar_cnt_d, rb_cnt_q, rb_cnt_d;
  logic              ar_valid, ar_fire;

  // Valid depends only on registered state, so it cannot drop before its handshake.
  assign ar_valid = issue_i && ((ar_cnt_q - rb_cnt_q) < MaxOut) && (ar_cnt_q < NumBursts);
  assign ar_fire  = ar_valid && arready_i;

  always_comb begin
    addr_d   = addr_q;
    ar_cnt_d = ar_cnt_q;
    rb_cnt_d = rb_cnt_q;
    if (load_i) begin
      addr_d   = start_addr_i;
      ar_cnt_d = '0;
      rb_cnt_d = '0;
    end else begin
      if (ar_fire) begin
        addr_d   = addr_q + AddrInc;
        ar_cnt_d = ar_cnt_q + 8'd1;
      end
      if (burst_done_i) rb_cnt_d = rb_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      addr_q   <= '0;
      ar_cnt_q <= '0;
      rb_cnt_q <= '0;
    end else begin
      addr_q   <= addr_d;
      ar_cnt_q <= ar_cnt_d;
      rb_cnt_q <= rb_cnt_d;
    end
  end

  always_comb begin
    ar_o = '0;
    if (ar_valid) begin
      ar_o.addr  = AxiAddrW'(addr_q);
      ar_o.len   = 8'(BURST_LEN - 1);
      ar_o.size  = 3'($clog2(DATA_W / 8));
      ar_o.burst = BurstIncr;
      ar_o.cache = ArCache;
      ar_o.valid = `HI;
    end
  end

  assign ar_cnt_o      = ar_cnt_q;
  assign r_burst_cnt_o = rb_cnt_q;

endmodule

// File: rtl/axi_line_reader.sv
// Multi-burst AXI line reader streaming R beats straight to dout.
// AXI_LINE_READER_ERR_EN enables sticky err on bad rresp or misplaced rlast.
module axi_line_reader
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W          = 29,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned BURST_LEN       = 240,
  parameter int unsigned BURSTS_PER_REQ  = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                 clk_i,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  axi_line_reader_if.master    axi,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_valid,
  output logic                 dout_last,
  input  logic                 dout_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [7:0] NumBursts = 8'(BURSTS_PER_REQ);

  lr_state_e   state_q, state_d;
  logic        load, r_fire, burst_done, last_burst;
  logic [7:0]  ar_cnt, r_burst_cnt;
  axi_ar_t     ar;
  logic        unused_r;

  assign load       = start && (state_q == StIdle);
  assign r_fire     = axi.axi_r.valid && axi.axi_rready;
  assign burst_done = r_fire && axi.axi_r.last;
  assign last_burst = (r_burst_cnt == NumBursts - 8'd1);

  axi_lr_ar_gen #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .BURST_LEN      (BURST_LEN),
    .BURSTS_PER_REQ (BURSTS_PER_REQ),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_ar_gen (
    .clk_i        (clk_i),
    .rst          (rst),
    .load_i       (load),
    .start_addr_i (start_addr),
    .issue_i      (state_q == StIssue),
    .arready_i    (axi.axi_arready),
    .burst_done_i (burst_done),
    .ar_o         (ar),
    .ar_cnt_o     (ar_cnt),
    .r_burst_cnt_o(r_burst_cnt)
  );

  assign axi.axi_ar = ar;

  always_comb begin
    state_d = state_q;
    busy    = `LO;
    done    = `LO;
    unique case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: begin
        busy = `HI;
        if (ar_cnt == NumBursts) state_d = StDrain;
      end
      StDrain: begin
        busy = `HI;
        // Look ahead at the final rlast so done follows the last beat by one cycle.
        if ((r_burst_cnt == NumBursts) || (burst_done && last_burst)) state_d = StDone;
      end
      StDone: begin
        busy    = `HI;
        done    = `HI;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  assign axi.axi_rready = dout_ready && busy;
  assign dout           = axi.axi_r.data[DATA_W-1:0];
  assign dout_valid     = axi.axi_r.valid && busy;
  assign dout_last      = dout_valid && axi.axi_r.last && last_burst;

`ifdef AXI_LINE_READER_ERR_EN
  localparam logic [7:0] LastBeat = 8'(BURST_LEN - 1);
  logic [7:0] beat_q, beat_d;
  logic       err_q, err_d;

  always_comb begin
    beat_d = beat_q;
    err_d  = err_q;
    if (load) begin
      beat_d = '0;
      err_d  = `LO;
    end else if (r_fire) begin
      beat_d = axi.axi_r.last ? 8'd0 : beat_q + 8'd1;
      if ((axi.axi_r.resp != RespOkay) || (axi.axi_r.last != (beat_q == LastBeat))) begin
        err_d = `HI;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      beat_q <= '0;
      err_q  <= `LO;
    end else begin
      beat_q <= beat_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = `LO;
`endif

  assign unused_r = ^{axi.axi_r.id, axi.axi_r.resp, axi.axi_r.data};

endmodule
